// File: rtl/ram_master_pkg.sv
// Shared types and sizing helpers for the RAM port master and its response buffer.
package ram_master_pkg;

    typedef enum logic {
        IDLE,
        RD
    } state_t;

    localparam int INFLIGHT_W = 2;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Show-ahead response buffer: head entry is visible on rdata whenever not empty.
module ram_rsp_fifo
    import ram_master_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [PW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ram_port_master.sv
// Requester for one synchronous RAM port: single writes, credit-limited burst reads,
// read data returned over a buffered valid/ready stream.
module ram_port_master
    import ram_master_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  busy,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int PW = ptr_width(FIFO_DEPTH);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [LEN_WIDTH-1:0]    beats_left;
    logic                    vld_p0, vld_p1;
    logic                    last_p0, last_p1;
    logic [INFLIGHT_W-1:0]   inflight;
    logic [PW+1:0]           credit_used;
    logic [PW:0]             fifo_count;
    logic                    fifo_full, fifo_empty;
    logic [DATA_WIDTH:0]     fifo_head;
    logic                    accept, can_issue, issue, issue_last;
    logic [ADDR_WIDTH-1:0]   issue_addr;

    assign inflight    = {1'b0, vld_p0} + {1'b0, vld_p1};
    assign credit_used = {1'b0, fifo_count} + {{PW{1'b0}}, inflight};
    // Every issued read owns a buffer slot, so captured data always has a home.
    assign can_issue   = !fifo_full && (credit_used < (PW+2)'(FIFO_DEPTH));
    assign cmd_ready   = rst_n && (state == IDLE);
    assign accept      = cmd_valid && cmd_ready;

    always_comb begin
        issue      = 1'b0;
        issue_addr = rd_addr;
        issue_last = (beats_left == '0);
        if (state == IDLE) begin
            issue      = accept && !cmd_we && can_issue;
            issue_addr = cmd_addr;
            issue_last = (cmd_len == '0);
        end else begin
            issue      = can_issue;
        end
    end

    // Stage p0: address on the port; p1: RAM has sampled it, ram_q valid next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_addr     <= '0;
            beats_left  <= '0;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            ram_wren <= 1'b0;
            vld_p0   <= issue;
            vld_p1   <= vld_p0;
            if (issue) ram_address <= issue_addr;
            case (state)
                IDLE: begin
                    if (accept && cmd_we) begin
                        ram_wren    <= 1'b1;
                        ram_address <= cmd_addr;
                        ram_data    <= cmd_wdata;
                    end else if (accept) begin
                        if (!issue) begin
                            state      <= RD;
                            rd_addr    <= cmd_addr;
                            beats_left <= cmd_len;
                        end else if (!issue_last) begin
                            state      <= RD;
                            rd_addr    <= cmd_addr + 1'b1;
                            beats_left <= cmd_len - 1'b1;
                        end
                    end
                end
                RD: begin
                    if (issue) begin
                        if (beats_left == '0) begin
                            state <= IDLE;
                        end else begin
                            rd_addr    <= rd_addr + 1'b1;
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        last_p0 <= issue_last;
        last_p1 <= last_p0;
    end

    // Stage p2: capture ram_q into the response buffer.
    ram_rsp_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_p1),
        .wdata ({last_p1, ram_q}),
        .pop   (rsp_ready),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign rsp_last  = !fifo_empty && fifo_head[DATA_WIDTH];
    assign busy      = (state != IDLE) || vld_p0 || vld_p1 || !fifo_empty;

endmodule

// File: tb/tb_ram_port_master.sv
// Scoreboard bench for ram_port_master with a one-cycle-latency RAM model.
module tb_ram_port_master;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int LW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_last, busy;
    logic [DW-1:0] rsp_data;
    logic          ram_wren;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data, ram_q;

    logic [DW-1:0] mem    [0:65535];
    logic [DW-1:0] shadow [0:65535];
    logic [DW:0]   sb_q [$];
    int            checks = 0;
    int            errors = 0;
    int            beats = 0;
    logic          toggle_mode = 1'b0;
    logic          ready_level = 1'b1;

    always #5 clk = ~clk;

    ram_port_master #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .busy        (busy),
        .ram_wren    (ram_wren),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_q       (ram_q)
    );

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
    end

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer-side ready: steady level, or one cycle on / three off.
    initial begin
        int phase;
        phase = 0;
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (toggle_mode) begin
                rsp_ready = (phase == 0);
                phase = (phase + 1) % 4;
            end else begin
                rsp_ready = ready_level;
                phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            logic [DW:0] exp;
            if (sb_q.size() == 0) begin
                check("unexpected_beat", sb_q.size(), 1);
            end else begin
                exp = sb_q.pop_front();
                check("rsp_data", rsp_data, exp[DW-1:0]);
                check("rsp_last", rsp_last, exp[DW]);
            end
            beats++;
        end
        if (rst_n) begin
            if (dut.u_fifo.count > FD) check("fifo_bound", dut.u_fifo.count, FD);
        end
    end

    task automatic send(input logic we, input logic [AW-1:0] addr,
                        input logic [LW-1:0] len, input logic [DW-1:0] wdata);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("cmd_accept_timeout", cmd_ready, 1);
        @(posedge clk);
        if (we) begin
            shadow[addr] = wdata;
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                logic [AW-1:0] a;
                a = addr + 16'(i);
                sb_q.push_back({(i == int'(len)), shadow[a]});
            end
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        check(tag, (n < 500), 1);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, n;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_wdata = '0;
        for (int i = 0; i < 65536; i++) shadow[i] = 16'(i) ^ 16'h5A5A;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_ram_wren", ram_wren, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_cmd_ready", cmd_ready, 1);

        // Write then single read of the same word
        send(1'b1, 16'h0010, 8'd0, 16'hBEEF);
        check("wr_wren", ram_wren, 1);
        check("wr_address", ram_address, 16'h0010);
        check("wr_data", ram_data, 16'hBEEF);
        @(posedge clk);
        #1;
        check("wr_wren_drop", ram_wren, 0);
        send(1'b0, 16'h0010, 8'd0, 16'h0);
        check("lat_k0", rsp_valid, 0);
        @(posedge clk);
        #1;
        check("lat_k1", rsp_valid, 0);
        @(posedge clk);
        #1;
        check("lat_k2", rsp_valid, 1);
        check("lat_k2_last", rsp_last, 1);
        wait_idle("single_read_done");

        // Streaming burst with consumer always ready
        for (int i = 0; i < 8; i++) send(1'b1, 16'h0100 + 16'(i), 8'd0, 16'hA000 + 16'(i));
        send(1'b0, 16'h0100, 8'd7, 16'h0);
        for (int i = 0; i <= 10; i++) begin
            if (i < 8) check("burst_addr", ram_address, 16'h0100 + 16'(i));
            check("burst_valid", rsp_valid, (i >= 2 && i < 10));
            @(posedge clk);
            #1;
        end
        check("burst_busy_clear", busy, 0);
        wait_idle("burst_done");

        // Same burst under heavy backpressure
        toggle_mode = 1'b1;
        send(1'b0, 16'h0100, 8'd7, 16'h0);
        repeat (6) @(posedge clk);
        #1;
        check("bp_issue_stalled", (ram_address < 16'h0107), 1);
        check("bp_busy", busy, 1);
        wait_idle("bp_done");
        toggle_mode = 1'b0;
        repeat (2) @(posedge clk);

        // Address wrap at the top of the space
        for (int i = 0; i < 4; i++) send(1'b1, 16'hFFFE + 16'(i), 8'd0, 16'hC000 + 16'(i));
        send(1'b0, 16'hFFFE, 8'd3, 16'h0);
        wait_idle("wrap_done");

        // Read immediately after write returns the new value
        send(1'b1, 16'h0020, 8'd0, 16'h5555);
        send(1'b1, 16'h0020, 8'd0, 16'h1234);
        send(1'b0, 16'h0020, 8'd0, 16'h0);
        wait_idle("raw_done");

        // Reset in the middle of a 16-beat burst
        b0 = beats;
        send(1'b0, 16'h0200, 8'd15, 16'h0);
        n = 0;
        while (beats < b0 + 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("midrst_reach_beat3", (n < 100), 1);
        #3;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_wren", ram_wren, 0);
        check("midrst_address", ram_address, 0);
        check("midrst_data", ram_data, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_data", rsp_data, 0);
        check("midrst_rsp_last", rsp_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_busy", busy, 0);
            check("post_rst_valid", rsp_valid, 0);
        end
        send(1'b0, 16'h0010, 8'd0, 16'h0);
        wait_idle("post_rst_read_done");
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_master.md
Name: ram_port_master

Overview:
- Requester-side controller for one port of the team's synchronous dual-port RAM.
- Accepts single writes and burst reads over a valid/ready command interface.
- Drives the RAM port signals (wren, address, data) and captures read data from the port's q.
- Returns read data over a valid/ready response stream with backpressure, so CPU/DMA clients never track RAM read latency.

Parameters:
- DATA_WIDTH, 16, RAM data width.
- ADDR_WIDTH, 16, RAM address width.
- LEN_WIDTH, 8, burst length field width; beats = cmd_len+1.
- FIFO_DEPTH, 4, response buffer entries; power of two, minimum 4.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready at the rising edge.
- cmd_we  in  1  1 = single write, 0 = burst read.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  read beats minus 1; ignored for writes.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read beat available.
- rsp_ready  in  1  consumer takes beat on valid&ready.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_last  out  1  final beat of the burst.
- busy  out  1  any command, in-flight read or buffered beat outstanding.
- ram_wren  out  1  to RAM wren.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_q  in  DATA_WIDTH  from RAM q.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; ram_wren=0, ram_address=0, ram_data=0; rsp_valid=0, rsp_last=0, rsp_data=0; busy=0; FIFO emptied; in-flight count cleared; cmd_ready forced 0 while rst_n low.
- RAM model: address/wren are sampled at edge E; read data is valid on ram_q after E and is captured by this block at E+1.
- All ram_* outputs are registered.
- States:
  - IDLE: cmd_ready=1.
  - RD: cmd_ready=0.
- Write accepted at edge k:
  - ram_wren=1, ram_address=cmd_addr, ram_data=cmd_wdata during cycle k..k+1.
  - ram_wren=0 afterwards.
  - State stays IDLE, so back-to-back writes run at one per cycle.
- Read accepted at edge k:
  - Latch the address; beat counter = cmd_len; go to RD.
  - First address is issued at edge k if issue is permitted; otherwise at the first later edge where it is.
- Issue rule: one read address per edge, only while fifo_count + inflight < FIFO_DEPTH.
  - inflight counts issued reads not yet captured; maximum 2.
  - A read is captured two edges after issue. The FIFO never overflows and ram_q is never dropped.
- Address increments by 1 per issued beat and wraps modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000).
- Return to IDLE on the edge that issues the last beat. A new command may be accepted the cycle after.
- Response latency: first rsp_valid is high from edge k+2 after acceptance at k.
- With rsp_ready held 1, N beats appear on N consecutive cycles.
- FIFO is show-ahead: rsp_data and rsp_last come from the head entry.
  - rsp_last is stored per entry and set on the beat whose counter is 0.
  - rsp_valid stays high and data stays stable until accepted.
- Capture and pop in the same edge are both honoured; the count is unchanged.
- Ordering:
  - A write accepted after a read burst sees the read issued first.
  - A read accepted after a write returns the new data, because the write reaches the RAM one edge before the read.
- busy = (state!=IDLE) | (inflight!=0) | (fifo_count!=0).
- Mid-operation reset: the burst is aborted; in-flight and buffered data are discarded; no rsp_valid until a new read.
- cmd_len=0 gives a single read with rsp_last=1.
- Maximum burst 2^LEN_WIDTH beats.

Decomposition:
- Package ram_master_pkg holds:
  - the state enum (IDLE, RD);
  - the inflight counter width (2 bits);
  - a function computing the FIFO pointer width from FIFO_DEPTH.
- Sub-module ram_rsp_fifo:
  - synchronous show-ahead FIFO, width DATA_WIDTH+1 (data plus last);
  - async active-low reset;
  - exposes count, push, pop, full, empty.

Test Plan:
- Write 0xBEEF to 0x0010, then read cmd_len=0 at 0x0010 -> ram_wren high exactly one cycle; rsp_valid at acceptance+2; rsp_data=0xBEEF, rsp_last=1.
- Preload 0x0100..0x0107 with 0xA000+i; read cmd_len=7 with rsp_ready=1 -> 8 consecutive beats 0xA000..0xA007; rsp_last only on beat 8; ram_address increments every cycle.
- Same burst with rsp_ready toggling 1 cycle on, 3 off -> no beat lost or duplicated; fifo_count never exceeds 4; ram_address stalls while the credit rule blocks issue.
- Read cmd_len=3 at 0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, in order; data matches preload.
- Write 0x1234 to 0x0020 then immediately read 0x0020 on the next accepted command -> returns 0x1234, not the stale value.
- Deassert rst_n mid-burst (beat 3 of 16) -> all outputs at reset values immediately; after release busy=0 and rsp_valid=0; a new single read returns correct data.
